// File: rtl/ps2_letter_decoder_if.sv
// rtl/ps2_letter_decoder_if.sv - PS/2 pin inputs and decoded-letter outputs of ps2_letter_decoder
interface ps2_letter_decoder_if;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic [25:0] letter;
  logic        letter_valid;
  logic        held;
  logic        frame_err;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  letter, letter_valid, held, frame_err
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output letter, letter_valid, held, frame_err
  );
endinterface

// File: rtl/ps2_letter_decoder.sv
// rtl/ps2_letter_decoder.sv - PS/2 Set-2 receiver and one-hot letter decoder
// Optional macro PS2_REPEAT_EN: when defined, typematic repeats of the held key emit again.
module ps2_letter_decoder #(
  parameter int FRAME_TIMEOUT = 50000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  ps2_letter_decoder_if.slave bus
);

  localparam int TW = $clog2(FRAME_TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {D_MAKE, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // Synchronisers preset high so reset release never looks like a falling edge.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus.PS2_CLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus.PS2_DAT};
      r_clk_prev <= w_clk_s;
    end
  end

  rx_state_t r_rx_state, w_rx_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tcnt;
  logic          r_byte_rdy;
  logic [7:0]    r_byte;
  logic          r_frame_err;
  logic          w_timeout;
  logic          w_good;
  logic          w_err;

  always_comb begin
    w_rx_next = r_rx_state;
    w_good    = 1'b0;
    w_err     = 1'b0;
    w_timeout = (r_rx_state != RX_IDLE) && !w_fall && (r_tcnt == TW'(FRAME_TIMEOUT - 1));
    if (w_timeout) begin
      w_rx_next = RX_IDLE;
      w_err     = 1'b1;
    end else if (w_fall) begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_dat_s) w_err = 1'b1;
          else         w_rx_next = RX_DATA;
        end
        RX_DATA: begin
          if (r_bit_cnt == 3'd7) w_rx_next = RX_PARITY;
        end
        RX_PARITY: w_rx_next = RX_STOP;
        RX_STOP: begin
          w_rx_next = RX_IDLE;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (w_dat_s && (^{r_shift, r_parity})) w_good = 1'b1;
          else                                   w_err  = 1'b1;
        end
        default: w_rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_rx_state  <= RX_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_parity    <= 1'b0;
      r_tcnt      <= '0;
      r_byte_rdy  <= 1'b0;
      r_byte      <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_next;
      r_byte_rdy  <= w_good;
      r_frame_err <= w_err;
      if (w_good) r_byte <= r_shift;
      if (w_fall || r_rx_state == RX_IDLE || w_timeout) r_tcnt <= '0;
      else                                              r_tcnt <= r_tcnt + 1'b1;
      if (w_fall && !w_timeout) begin
        case (r_rx_state)
          RX_IDLE:   r_bit_cnt <= 3'd0;
          RX_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          RX_PARITY: r_parity <= w_dat_s;
          default:   r_bit_cnt <= r_bit_cnt;
        endcase
      end
    end
  end

  function automatic logic [5:0] letter_lookup(input logic [7:0] code);
    logic [5:0] m;
    m = 6'd0;
    case (code)
      8'h1C: m = {1'b1, 5'd0};   8'h32: m = {1'b1, 5'd1};   8'h21: m = {1'b1, 5'd2};
      8'h23: m = {1'b1, 5'd3};   8'h24: m = {1'b1, 5'd4};   8'h2B: m = {1'b1, 5'd5};
      8'h34: m = {1'b1, 5'd6};   8'h33: m = {1'b1, 5'd7};   8'h43: m = {1'b1, 5'd8};
      8'h3B: m = {1'b1, 5'd9};   8'h42: m = {1'b1, 5'd10};  8'h4B: m = {1'b1, 5'd11};
      8'h3A: m = {1'b1, 5'd12};  8'h31: m = {1'b1, 5'd13};  8'h44: m = {1'b1, 5'd14};
      8'h4D: m = {1'b1, 5'd15};  8'h15: m = {1'b1, 5'd16};  8'h2D: m = {1'b1, 5'd17};
      8'h1B: m = {1'b1, 5'd18};  8'h2C: m = {1'b1, 5'd19};  8'h3C: m = {1'b1, 5'd20};
      8'h2A: m = {1'b1, 5'd21};  8'h1D: m = {1'b1, 5'd22};  8'h22: m = {1'b1, 5'd23};
      8'h35: m = {1'b1, 5'd24};  8'h1A: m = {1'b1, 5'd25};
      default: m = 6'd0;
    endcase
    return m;
  endfunction

  dec_state_t r_dec_state, w_dec_next;
  logic [25:0] r_letter;
  logic        r_letter_valid;
  logic        r_held;
  logic [7:0]  r_held_code;
  logic [5:0]  w_map;
  logic        w_suppress;
  logic        w_emit;
  logic        w_release;

  assign w_map = letter_lookup(r_byte);

`ifdef PS2_REPEAT_EN
  assign w_suppress = 1'b0;
`else
  assign w_suppress = r_held && (r_byte == r_held_code);
`endif

  always_comb begin
    w_dec_next = r_dec_state;
    w_emit     = 1'b0;
    w_release  = 1'b0;
    if (r_byte_rdy) begin
      case (r_dec_state)
        D_MAKE: begin
          if (r_byte == 8'hF0)             w_dec_next = D_BREAK;
          else if (r_byte == 8'hE0)        w_dec_next = D_EXT;
          else if (w_map[5] && !w_suppress) w_emit    = 1'b1;
        end
        D_BREAK: begin
          w_dec_next = D_MAKE;
          w_release  = r_held && (r_byte == r_held_code);
        end
        D_EXT:       w_dec_next = (r_byte == 8'hF0) ? D_EXT_BREAK : D_MAKE;
        D_EXT_BREAK: w_dec_next = D_MAKE;
        default:     w_dec_next = D_MAKE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_dec_state    <= D_MAKE;
      r_letter       <= 26'd0;
      r_letter_valid <= 1'b0;
      r_held         <= 1'b0;
      r_held_code    <= 8'd0;
    end else begin
      r_dec_state    <= w_dec_next;
      r_letter_valid <= w_emit;
      if (w_emit) begin
        r_letter    <= 26'd1 << w_map[4:0];
        r_held      <= 1'b1;
        r_held_code <= r_byte;
      end else if (w_release) begin
        r_held <= 1'b0;
      end
    end
  end

  assign bus.letter       = r_letter;
  assign bus.letter_valid = r_letter_valid;
  assign bus.held         = r_held;
  assign bus.frame_err    = r_frame_err;

endmodule
